// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Program-counter generator for the fetch stage. Presents
//            sequential fetch addresses over a valid/ready handshake, honours
//            a pipeline stall, takes prioritised redirects (trap above
//            branch), tags each redirect with a wrapping epoch, and parks
//            fetch in a halt mode until the next redirect.
// Ports    : clk          - clock, rising-edge
//            rst          - synchronous reset, active-low
//            stall_i      - blocks sequential advance (not redirects)
//            halt_i       - request to stop issuing (WFI / debug)
//            trap_valid_i - trap redirect request (highest priority)
//            trap_addr_i  - trap target
//            br_valid_i   - branch/jump redirect request
//            br_addr_i    - branch target
//            pc_ready_i   - fetch unit accepts pc_o this cycle
//            pc_valid_o   - pc_o holds a fetch request
//            pc_o         - fetch address
//            epoch_o      - epoch tag of pc_o
//            redirected_o - pc_o is the first address after redirect/boot
//            misalign_o   - last redirect target had nonzero low bits
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int unsigned       STEP       = 4,
  parameter int unsigned       ALIGN_BITS = 2,
  parameter int unsigned       EPOCH_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic              pc_ready_i,
  output logic              pc_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic              redirected_o,
  output logic              misalign_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0]  c_step      = ADDR_W'(STEP);
  localparam logic [EPOCH_W-1:0] c_epoch_one = EPOCH_W'(1);

  // Registered state and outputs
  state_t               state_q,    state_d;
  logic [ADDR_W-1:0]    npc_q,      npc_d;
  logic [ADDR_W-1:0]    pc_q,       pc_d;
  logic                 valid_q,    valid_d;
  logic [EPOCH_W-1:0]   epoch_q,    epoch_d;
  logic                 redir_q,    redir_d;
  logic                 mis_q,      mis_d;

  // Redirect selection
  logic                 w_redirect;
  logic [ADDR_W-1:0]    w_target;
  logic [ADDR_W-1:0]    w_target_aln;
  logic                 w_target_mis;
  logic                 w_slot_free;

  assign w_redirect = trap_valid_i | br_valid_i;
  // Trap outranks branch when both fire in the same cycle.
  assign w_target   = trap_valid_i ? trap_addr_i : br_addr_i;

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign w_target_aln = {w_target[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
      assign w_target_mis = |w_target[ALIGN_BITS-1:0];
    end else begin : g_no_align
      assign w_target_aln = w_target;
      assign w_target_mis = 1'b0;
    end
  endgenerate

  // The current address is gone (or was never there) and the pipe can take
  // a new one; a stall blocks sequential advance even if fetch is ready.
  assign w_slot_free = (~valid_q | pc_ready_i) & ~stall_i;

  always_comb begin
    state_d = state_q;
    npc_d   = npc_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    epoch_d = epoch_q;
    redir_d = redir_q;
    mis_d   = mis_q;

    if (w_redirect) begin
      // A redirect overrides stall, halt and handshake state; any address
      // not yet accepted is simply replaced and never re-presented.
      pc_d    = w_target_aln;
      valid_d = 1'b1;
      npc_d   = w_target_aln + c_step;
      epoch_d = epoch_q + c_epoch_one;
      redir_d = 1'b1;
      mis_d   = w_target_mis;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: begin
          pc_d    = RESET_VEC;
          valid_d = 1'b1;
          npc_d   = RESET_VEC + c_step;
          redir_d = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (w_slot_free) begin
            if (halt_i) begin
              valid_d = 1'b0;
              state_d = ST_HALT;
            end else begin
              pc_d    = npc_q;
              valid_d = 1'b1;
              npc_d   = npc_q + c_step;
              redir_d = 1'b0;
            end
          end
        end
        ST_HALT: begin
          // Only a redirect leaves HALT; dropping halt_i does nothing.
          valid_d = 1'b0;
        end
        default: begin
          state_d = ST_BOOT;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      npc_q   <= RESET_VEC;
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      epoch_q <= '0;
      redir_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      npc_q   <= npc_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      epoch_q <= epoch_d;
      redir_q <= redir_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_valid_o   = valid_q;
  assign pc_o         = pc_q;
  assign epoch_o      = epoch_q;
  assign redirected_o = redir_q;
  assign misalign_o   = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_gen
// Purpose  : Self-checking bench for pc_gen (default parameters). Directed
//            vector table, an epoch-wrap sequence, and a randomized phase
//            compared against a behavioural fetch-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;
  localparam int   ALIGN_UNIT = 4;
  localparam int   N_VEC = 30;
  localparam int   N_RAND = 3000;

  logic        clk;
  logic        rst;
  logic        stall_i, halt_i, trap_valid_i, br_valid_i, pc_ready_i;
  logic [31:0] trap_addr_i, br_addr_i;
  logic        pc_valid_o, redirected_o, misalign_o;
  logic [31:0] pc_o;
  logic [1:0]  epoch_o;

  int n_checks = 0;
  int n_err    = 0;

  pc_gen dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .halt_i       (halt_i),
    .trap_valid_i (trap_valid_i),
    .trap_addr_i  (trap_addr_i),
    .br_valid_i   (br_valid_i),
    .br_addr_i    (br_addr_i),
    .pc_ready_i   (pc_ready_i),
    .pc_valid_o   (pc_valid_o),
    .pc_o         (pc_o),
    .epoch_o      (epoch_o),
    .redirected_o (redirected_o),
    .misalign_o   (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Behavioural model: a fetch stream described by its presented address,
  // the next sequential address, and whether fetch is booting or parked.
  // ---------------------------------------------------------------------
  logic [31:0] m_pc, m_next;
  logic        m_valid, m_redir, m_mis;
  int          m_epoch;
  bit          m_booting, m_parked;

  task automatic model_step();
    logic [31:0] tgt;
    if (!rst) begin
      m_pc = 32'h0; m_next = 32'h0; m_valid = 1'b0; m_epoch = 0;
      m_redir = 1'b0; m_mis = 1'b0; m_booting = 1'b1; m_parked = 1'b0;
    end else if (trap_valid_i || br_valid_i) begin
      tgt     = trap_valid_i ? trap_addr_i : br_addr_i;
      m_pc    = tgt - (tgt % ALIGN_UNIT);
      m_next  = m_pc + 32'd4;
      m_valid = 1'b1;
      m_epoch = (m_epoch + 1) % 4;
      m_redir = 1'b1;
      m_mis   = (tgt % ALIGN_UNIT) != 0;
      m_booting = 1'b0; m_parked = 1'b0;
    end else if (m_booting) begin
      m_pc = 32'h0; m_next = 32'h4; m_valid = 1'b1; m_redir = 1'b1;
      m_booting = 1'b0;
    end else if (m_parked) begin
      m_valid = 1'b0;
    end else if ((!m_valid || pc_ready_i) && !stall_i) begin
      if (halt_i) begin
        m_valid = 1'b0; m_parked = 1'b1;
      end else begin
        m_pc = m_next; m_next = m_next + 32'd4; m_valid = 1'b1; m_redir = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Drive inputs (called just after a falling edge), clock once, advance the
  // model, and return at the next falling edge where outputs are sampled.
  task automatic apply(input logic r, input logic s, input logic h,
                       input logic tv, input logic [31:0] ta,
                       input logic bv, input logic [31:0] ba,
                       input logic rdy);
    rst = r; stall_i = s; halt_i = h; trap_valid_i = tv; trap_addr_i = ta;
    br_valid_i = bv; br_addr_i = ba; pc_ready_i = rdy;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        r, s, h, tv;
    logic [31:0] ta;
    logic        bv;
    logic [31:0] ba;
    logic        rdy;
    logic        v;
    logic [31:0] pc;
    logic [1:0]  ep;
    logic        rd, ms;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic h,
                              input logic tv, input logic [31:0] ta,
                              input logic bv, input logic [31:0] ba,
                              input logic rdy, input logic v,
                              input logic [31:0] pc, input logic [1:0] ep,
                              input logic rd, input logic ms);
    vec_t t;
    t.r = r; t.s = s; t.h = h; t.tv = tv; t.ta = ta; t.bv = bv; t.ba = ba;
    t.rdy = rdy; t.v = v; t.pc = pc; t.ep = ep; t.rd = rd; t.ms = ms;
    return t;
  endfunction

  vec_t tbl [N_VEC];

  initial begin
    //            rst stl hlt tv  ta           bv  ba           rdy | v  pc           ep    rd ms
    tbl[0]  = mk(L, L, L, L, 32'h0,        L, 32'h0,        H,  L, 32'h0,        2'd0, L, L);
    tbl[1]  = mk(L, L, L, L, 32'h0,        L, 32'h0,        H,  L, 32'h0,        2'd0, L, L);
    tbl[2]  = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h0,        2'd0, H, L);
    tbl[3]  = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h4,        2'd0, L, L);
    tbl[4]  = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h8,        2'd0, L, L);
    tbl[5]  = mk(H, L, L, L, 32'h0,        L, 32'h0,        L,  H, 32'h8,        2'd0, L, L);
    tbl[6]  = mk(H, L, L, L, 32'h0,        L, 32'h0,        L,  H, 32'h8,        2'd0, L, L);
    tbl[7]  = mk(H, L, L, L, 32'h0,        L, 32'h0,        L,  H, 32'h8,        2'd0, L, L);
    tbl[8]  = mk(H, H, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h8,        2'd0, L, L);
    tbl[9]  = mk(H, H, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h8,        2'd0, L, L);
    tbl[10] = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  H, 32'hC,        2'd0, L, L);
    tbl[11] = mk(H, H, L, H, 32'h100,      H, 32'h200,      L,  H, 32'h100,      2'd1, H, L);
    tbl[12] = mk(H, H, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h100,      2'd1, H, L);
    tbl[13] = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h104,      2'd1, L, L);
    tbl[14] = mk(H, L, L, L, 32'h0,        H, 32'hFFFFFFFE, L,  H, 32'hFFFFFFFC, 2'd2, H, H);
    tbl[15] = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h0,        2'd2, L, H);
    tbl[16] = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h4,        2'd2, L, H);
    tbl[17] = mk(H, L, L, L, 32'h0,        H, 32'h20,       H,  H, 32'h20,       2'd3, H, L);
    tbl[18] = mk(H, L, H, L, 32'h0,        L, 32'h0,        H,  L, 32'h20,       2'd3, H, L);
    tbl[19] = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  L, 32'h20,       2'd3, H, L);
    tbl[20] = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  L, 32'h20,       2'd3, H, L);
    tbl[21] = mk(H, L, L, L, 32'h0,        H, 32'h40,       L,  H, 32'h40,       2'd0, H, L);
    tbl[22] = mk(H, L, L, L, 32'h0,        H, 32'h80,       H,  H, 32'h80,       2'd1, H, L);
    tbl[23] = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h84,       2'd1, L, L);
    tbl[24] = mk(H, L, H, L, 32'h0,        L, 32'h0,        H,  L, 32'h84,       2'd1, L, L);
    tbl[25] = mk(L, L, H, L, 32'h0,        H, 32'h200,      H,  L, 32'h0,        2'd0, L, L);
    tbl[26] = mk(H, H, H, L, 32'h0,        L, 32'h0,        L,  H, 32'h0,        2'd0, H, L);
    tbl[27] = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h4,        2'd0, L, L);
    tbl[28] = mk(H, L, H, L, 32'h0,        H, 32'h300,      H,  H, 32'h300,      2'd1, H, L);
    tbl[29] = mk(H, L, L, L, 32'h0,        L, 32'h0,        H,  H, 32'h304,      2'd1, L, L);

    rst = 1'b0; stall_i = 1'b0; halt_i = 1'b0; trap_valid_i = 1'b0;
    br_valid_i = 1'b0; trap_addr_i = 32'h0; br_addr_i = 32'h0; pc_ready_i = 1'b0;
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < N_VEC; i++) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].tv, tbl[i].ta,
            tbl[i].bv, tbl[i].ba, tbl[i].rdy);
      check("vec_valid", i, 32'(pc_valid_o),   32'(tbl[i].v));
      check("vec_pc",    i, pc_o,              tbl[i].pc);
      check("vec_epoch", i, 32'(epoch_o),      32'(tbl[i].ep));
      check("vec_redir", i, 32'(redirected_o), 32'(tbl[i].rd));
      check("vec_mis",   i, 32'(misalign_o),   32'(tbl[i].ms));
    end

    // Back-to-back traps from a fresh boot: epoch walks 1,2,3 then wraps to 0.
    apply(L, L, L, L, 32'h0, L, 32'h0, L);
    for (int k = 0; k < 4; k++) begin
      apply(H, H, L, H, 32'h1000 * (k + 1) + 32'h1, L, 32'h0, L);
      check("wrap_epoch", k, 32'(epoch_o), (k + 1) % 4);
      check("wrap_pc",    k, pc_o,         32'h1000 * (k + 1));
      check("wrap_mis",   k, 32'(misalign_o), 32'd1);
    end

    // Randomized phase against the model
    apply(L, L, L, L, 32'h0, L, 32'h0, L);
    for (int n = 0; n < N_RAND; n++) begin
      logic        r, s, h, tv, bv, rdy;
      logic [31:0] ta, ba;
      r   = ($urandom_range(99) >= 2);
      s   = ($urandom_range(99) < 20);
      h   = ($urandom_range(99) < 8);
      tv  = ($urandom_range(99) < 4);
      bv  = ($urandom_range(99) < 7);
      rdy = ($urandom_range(99) < 70);
      ta  = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15)))
                                     : $urandom;
      ba  = ($urandom_range(1) == 0) ? 32'($urandom_range(1023)) : $urandom;
      apply(r, s, h, tv, ta, bv, ba, rdy);
      check("rnd_valid", n, 32'(pc_valid_o),   32'(m_valid));
      if (m_valid) check("rnd_pc", n, pc_o, m_pc);
      check("rnd_epoch", n, 32'(epoch_o),      32'(m_epoch));
      check("rnd_redir", n, 32'(redirected_o), 32'(m_redir));
      check("rnd_mis",   n, 32'(misalign_o),   32'(m_mis));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It issues sequential fetch addresses to the instruction fetch unit over a valid/ready handshake and honours a pipeline stall. It accepts two prioritised redirect sources: trap above branch. Every redirect tags subsequent addresses with a wrapping epoch so downstream stages can discard wrong-path instructions, and a halt mode parks fetch until the next redirect.

## Interface
- ADDR_W, 32: address width.
- RESET_VEC, 0: first fetch address after reset.
- STEP, 4: increment between sequential addresses.
- ALIGN_BITS, 2: low address bits that must be zero; 0 disables alignment checking.
- EPOCH_W, 2: epoch tag width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- stall_i  in  1  pipeline stall; blocks sequential advance only.
- halt_i  in  1  request to stop issuing (WFI/debug).
- trap_valid_i  in  1  trap/exception redirect request.
- trap_addr_i  in  ADDR_W  trap target.
- br_valid_i  in  1  branch/jump redirect request from execute.
- br_addr_i  in  ADDR_W  branch target.
- pc_ready_i  in  1  fetch unit accepts pc_o this cycle.
- pc_valid_o  out  1  pc_o holds a fetch request.
- pc_o  out  ADDR_W  fetch address.
- epoch_o  out  EPOCH_W  epoch of pc_o.
- redirected_o  out  1  pc_o is the first address after a redirect or boot.
- misalign_o  out  1  last redirect target had nonzero low ALIGN_BITS.

## Operation
- Internal state: npc (ADDR_W), epoch (EPOCH_W), and a state machine with states BOOT, RUN and HALT.
- Reset (rst==0 at an edge), regardless of any other input:
  - pc_o=RESET_VEC, pc_valid_o=0, epoch_o=0, redirected_o=0, misalign_o=0.
  - npc=RESET_VEC, state=BOOT.
- Slot free means (!pc_valid_o || pc_ready_i) && !stall_i.
- Redirect: trap_valid_i || br_valid_i. Trap wins if both are asserted. A redirect is accepted in every state, ignores stall_i, halt_i and pc_ready_i, and flushes any unaccepted pc_o. On a redirect:
  - pc_o = target with low ALIGN_BITS forced to 0.
  - pc_valid_o=1, npc=aligned target+STEP, epoch_o=epoch_o+1 (wraps mod 2^EPOCH_W).
  - redirected_o=1, misalign_o=|target[ALIGN_BITS-1:0].
  - state=RUN.
- BOOT, no redirect: pc_o=RESET_VEC, pc_valid_o=1, npc=RESET_VEC+STEP, redirected_o=1, state=RUN. halt_i and stall_i are ignored.
- RUN, no redirect, slot free:
  - If halt_i: pc_valid_o=0, state=HALT.
  - Otherwise: pc_o=npc, pc_valid_o=1, npc=npc+STEP, redirected_o=0.
  - misalign_o holds.
- RUN, no redirect, slot not free: all outputs hold (valid/ready stability rule).
- HALT: pc_valid_o=0 and the other outputs hold. Exit only via redirect; a halt_i deassertion alone does not resume fetch.
- Arithmetic: npc+STEP is modulo 2^ADDR_W; 0xFFFFFFFC+4 gives 0x00000000 with no flag.

## Timing
- Redirect sampled at edge N: the new pc_o/pc_valid_o is visible after edge N. The unaccepted address present before edge N is never re-presented.
- Sustained throughput is one address per cycle while pc_ready_i=1 and stall_i=0.
- Boot latency: the first valid address appears one edge after rst deasserts.
- redirected_o is high for exactly the first presented address of each epoch. It stays high while that address waits for pc_ready_i.
- A redirect in the same cycle as pc_ready_i=1: the old address counts as consumed, and the redirect target is presented next.
- A redirect and halt_i in the same cycle: the redirect wins and the state is RUN. halt_i must be held to take effect later.
- Reset mid-operation, including HALT or a pending redirect: takes effect at that edge and drops all state.

## Test plan
- Boot: rst low 2 cycles then high, ready=1, defaults → pc_o 0,4,8,12 on consecutive cycles. redirected_o=1 only with 0; epoch_o=0.
- Backpressure/stall: ready=0 for 3 cycles while pc_o=8, then stall_i=1 for 2 cycles with ready=1 → pc_o holds 8 throughout, advances to 12 on the first cycle after stall drops.
- Redirect priority: trap 0x100 and branch 0x200 in the same cycle while stalled → pc_o=0x100, epoch_o=1, redirected_o=1, then 0x104.
- Misaligned target and wrap: branch to 0xFFFFFFFE → pc_o=0xFFFFFFFC, misalign_o=1, next 0x00000000. Four redirects from epoch 0 → epoch_o=0 (EPOCH_W=2).
- Halt: halt_i=1 in RUN at pc_o=0x20 accepted → pc_valid_o=0. halt_i drops → stays invalid. Branch 0x40 → pc_o=0x40, valid=1.
- Reset mid-run: rst low while pc_o=0x84 in HALT → pc_o=0, pc_valid_o=0, epoch_o=0. Reboot presents 0 again.
